// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port byte memory among NREQ requesters (0=CPU, 1=GPU, 2=display).
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority, lowest index wins.
module mem_arbiter #(
  parameter int NREQ    = 3,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_rd,
  input  logic [NREQ-1:0]          req_wr,
  input  logic [NREQ*ADDR_W-1:0]   req_idx,
  input  logic [NREQ*DATA_W-1:0]   req_wbyte,
  output logic [NREQ-1:0]          rd_ack,
  output logic [NREQ-1:0]          wr_ack,
  output logic [DATA_W-1:0]        rd_byte,
  output logic                     timeout_err,
  output logic                     mem_read,
  output logic [ADDR_W-1:0]        mem_read_idx,
  input  logic [DATA_W-1:0]        mem_read_byte,
  input  logic                     mem_read_ack,
  output logic                     mem_write,
  output logic [ADDR_W-1:0]        mem_write_idx,
  output logic [DATA_W-1:0]        mem_write_byte
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;

  typedef enum logic [1:0] {IDLE, WR_ISSUE, RD_WAIT} state_t;

  state_t            state, state_nxt;
  logic [GW-1:0]     grant;
  logic [ADDR_W-1:0] idx_q;
  logic [DATA_W-1:0] byte_q;
  logic [CW-1:0]     tmo_cnt;
  logic              tmo_hit;
  logic [NREQ-1:0]   pending;
  logic              found;
  logic [GW-1:0]     winner;
  logic [ADDR_W-1:0] sel_idx;
  logic [DATA_W-1:0] sel_byte;

  assign pending = req_rd | req_wr;
  assign found   = |pending;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic [GW-1:0] last;

  // Walk the search order backwards so the candidate closest to last+1 is written last.
  always_comb begin
    int cand;
    winner = '0;
    cand   = 0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = (int'(last) + k) % NREQ;
      if (pending[cand]) winner = GW'(cand);
    end
  end
`else
  always_comb begin
    winner = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (pending[i]) winner = GW'(i);
    end
  end
`endif

  always_comb begin
    sel_idx  = '0;
    sel_byte = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == GW'(i)) begin
        sel_idx  = req_idx[i*ADDR_W +: ADDR_W];
        sel_byte = req_wbyte[i*DATA_W +: DATA_W];
      end
    end
  end

  // Arbitration register stage: grant, address and write data captured in IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= '0;
      idx_q       <= '0;
      byte_q      <= '0;
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last        <= GW'(NREQ - 1);
`endif
    end else begin
      state <= state_nxt;
      if (state == IDLE && found) begin
        grant  <= winner;
        idx_q  <= sel_idx;
        byte_q <= sel_byte;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last   <= winner;
`endif
      end
      if (state == RD_WAIT) tmo_cnt <= tmo_cnt + 1'b1;
      else                  tmo_cnt <= '0;
      if (tmo_hit) timeout_err <= 1'b1;
    end
  end

  // Access stage: strobes and acks decoded from state; read data passes straight through
  always_comb begin
    state_nxt = state;
    rd_ack    = '0;
    wr_ack    = '0;
    rd_byte   = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      IDLE: begin
        if (found) state_nxt = req_wr[winner] ? WR_ISSUE : RD_WAIT;
      end
      WR_ISSUE: begin
        mem_write     = 1'b1;
        wr_ack[grant] = 1'b1;
        state_nxt     = IDLE;
      end
      RD_WAIT: begin
        mem_read = 1'b1;
        // A real ack in the timeout cycle still counts as a normal completion.
        if (mem_read_ack) begin
          rd_ack[grant] = 1'b1;
          rd_byte       = mem_read_byte;
          state_nxt     = IDLE;
        end else if (tmo_cnt == CW'(TIMEOUT)) begin
          rd_ack[grant] = 1'b1;
          tmo_hit       = 1'b1;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_read_idx   = idx_q;
  assign mem_write_idx  = idx_q;
  assign mem_write_byte = byte_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random request batches
// checked against a service-order model (fixed priority or round-robin per MEM_ARB_ROUND_ROBIN_EN).
module tb_mem_arbiter;
  localparam int NREQ = 3, ADDR_W = 12, DATA_W = 8, TIMEOUT = 15;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NREQ-1:0]        req_rd, req_wr;
  logic [NREQ*ADDR_W-1:0] req_idx;
  logic [NREQ*DATA_W-1:0] req_wbyte;
  logic [NREQ-1:0]        rd_ack, wr_ack;
  logic [DATA_W-1:0]      rd_byte;
  logic                   timeout_err;
  logic                   mem_read;
  logic [ADDR_W-1:0]      mem_read_idx;
  logic [DATA_W-1:0]      mem_read_byte;
  logic                   mem_read_ack;
  logic                   mem_write;
  logic [ADDR_W-1:0]      mem_write_idx;
  logic [DATA_W-1:0]      mem_write_byte;

  mem_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req_rd(req_rd), .req_wr(req_wr), .req_idx(req_idx),
    .req_wbyte(req_wbyte), .rd_ack(rd_ack), .wr_ack(wr_ack), .rd_byte(rd_byte),
    .timeout_err(timeout_err), .mem_read(mem_read), .mem_read_idx(mem_read_idx),
    .mem_read_byte(mem_read_byte), .mem_read_ack(mem_read_ack), .mem_write(mem_write),
    .mem_write_idx(mem_write_idx), .mem_write_byte(mem_write_byte)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                req;
    bit                wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    bit                to;
  } exp_t;

  exp_t              exp_q[$];
  int                lat_q[$];
  logic [DATA_W-1:0] env_mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] m_mem   [0:(1<<ADDR_W)-1];
  int                m_last;
  bit                m_terr;
  bit                hold;
  bit                force_stray;
  bit                got_ack;
  int                rw_cnt, cur_lat;
  int                n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] p);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= NREQ; k++) begin
      if (p[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
    end
`else
    for (int i = 0; i < NREQ; i++) begin
      if (p[i]) return i;
    end
`endif
    return -1;
  endfunction

  // One clock: memory responds at the negedge, DUT outputs sampled 1 time unit later.
  task automatic cyc();
    logic [NREQ-1:0] any;
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    if (mem_read) begin
      if (rw_cnt == 0) cur_lat = (lat_q.size() > 0) ? lat_q.pop_front() : 1000;
      mem_read_ack  = (rw_cnt == cur_lat);
      mem_read_byte = mem_read_ack ? env_mem[mem_read_idx] : DATA_W'($urandom);
      rw_cnt++;
    end else begin
      rw_cnt        = 0;
      mem_read_ack  = force_stray || ($urandom_range(0, 3) == 0);
      mem_read_byte = DATA_W'($urandom);
    end
    #1;
    any     = rd_ack | wr_ack;
    got_ack = (any != 0);
    chk("ack_onehot", 32'($countones(any) <= 1), 32'd1);
    chk("strobe_excl", 32'(mem_read & mem_write), 32'd0);
    chk("timeout_err", 32'(timeout_err), 32'(m_terr));
    if (any != 0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", 32'(any), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("ack_who", 32'(any), 32'(1 << e.req));
        chk("ack_kind", 32'(wr_ack != 0), 32'(e.wr));
        if (e.wr) begin
          chk("wr_idx", 32'(mem_write_idx), 32'(e.addr));
          chk("wr_byte", 32'(mem_write_byte), 32'(e.data));
        end else begin
          chk("rd_byte", 32'(rd_byte), 32'(e.data));
          chk("rd_idx", 32'(mem_read_idx), 32'(e.addr));
          if (e.to) m_terr = 1'b1;
        end
        if (hold) begin
          if (exp_q.size() == 0) begin
            req_rd = '0;
            req_wr = '0;
          end
        end else if (e.wr) begin
          req_wr[e.req] = 1'b0;
        end else begin
          req_rd[e.req] = 1'b0;
        end
      end
    end
    if (mem_write) env_mem[mem_write_idx] = mem_write_byte;
  endtask

  // Predict service order and results for a batch raised in one cycle; lat<0 picks random latencies.
  task automatic launch(input logic [NREQ-1:0] rd, input logic [NREQ-1:0] wr,
                        input logic [NREQ*ADDR_W-1:0] idx, input logic [NREQ*DATA_W-1:0] wb,
                        input int lat);
    logic [NREQ-1:0] pr, pw;
    int w, l;
    exp_t e;
    pr = rd;
    pw = wr;
    while ((pr | pw) != 0) begin
      w      = pick(pr | pw);
      e.req  = w;
      e.addr = idx[w*ADDR_W +: ADDR_W];
      if (pw[w]) begin
        e.wr   = 1'b1;
        e.to   = 1'b0;
        e.data = wb[w*DATA_W +: DATA_W];
        m_mem[e.addr] = e.data;
        pw[w] = 1'b0;
      end else begin
        l = (lat >= 0) ? lat : (($urandom_range(0, 15) == 0) ? 40 : int'($urandom_range(0, 4)));
        lat_q.push_back(l);
        e.wr   = 1'b0;
        e.to   = (l > TIMEOUT);
        e.data = e.to ? '0 : m_mem[e.addr];
        pr[w] = 1'b0;
      end
      exp_q.push_back(e);
      m_last = w;
    end
    req_idx   = idx;
    req_wbyte = wb;
    req_rd    = rd;
    req_wr    = wr;
  endtask

  task automatic run(output int first);
    first = -1;
    for (int n = 1; n <= 400 && exp_q.size() > 0; n++) begin
      cyc();
      if (got_ack && first < 0) first = n;
    end
    chk("batch_done", 32'(exp_q.size()), 32'd0);
    cyc();
    cyc();
  endtask

  initial begin
    int first;
    int w;
    exp_t e;
    logic [NREQ-1:0] rr, ww;
    for (int a = 0; a < (1 << ADDR_W); a++) begin
      env_mem[a] = DATA_W'($urandom);
      m_mem[a]   = env_mem[a];
    end
    reset = 1'b1; req_rd = '0; req_wr = '0; req_idx = '0; req_wbyte = '0;
    mem_read_ack = 1'b0; mem_read_byte = '0;
    hold = 1'b0; force_stray = 1'b0; m_terr = 1'b0; m_last = NREQ - 1;
    rw_cnt = 0; cur_lat = 0;
    cyc();
    cyc();
    reset = 1'b0;
    chk("rst_rd_ack", 32'(rd_ack), 32'd0);
    chk("rst_wr_ack", 32'(wr_ack), 32'd0);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_read_idx", 32'(mem_read_idx), 32'd0);
    chk("rst_write_idx", 32'(mem_write_idx), 32'd0);
    chk("rst_write_byte", 32'(mem_write_byte), 32'd0);
    chk("rst_rd_byte", 32'(rd_byte), 32'd0);
    cyc();

    // GPU write alone: ack in the cycle after the request is seen
    launch(3'b000, 3'b010, {12'h0, 12'h100, 12'h0}, {8'h0, 8'hFF, 8'h0}, -1);
    run(first);
    chk("wr_latency", 32'(first), 32'd1);
    chk("mem_0x100", 32'(env_mem[12'h100]), 32'hFF);

    // Simultaneous CPU/GPU reads
    env_mem[12'h042] = 8'hFF; m_mem[12'h042] = 8'hFF;
    env_mem[12'h043] = 8'hC3; m_mem[12'h043] = 8'hC3;
    launch(3'b011, 3'b000, {12'h0, 12'h043, 12'h042}, '0, 2);
    run(first);

    // CPU read and write together: write first, read returns the new byte
    launch(3'b001, 3'b001, {12'h0, 12'h0, 12'h200}, {8'h0, 8'h0, 8'h5A}, 1);
    run(first);

    // Ack arriving exactly at the timeout count completes normally
    launch(3'b100, 3'b000, {12'h077, 12'h0, 12'h0}, '0, TIMEOUT);
    run(first);
    chk("edge_latency", 32'(first), 32'(TIMEOUT + 1));

    // Silent memory: forced completion with zero data and sticky error
    launch(3'b001, 3'b000, {12'h0, 12'h0, 12'h123}, '0, 99);
    run(first);
    chk("timeout_latency", 32'(first), 32'(TIMEOUT + 1));

    // All three reading continuously for 9 grants
    hold = 1'b1;
    for (int k = 0; k < 9; k++) begin
      w      = pick(3'b111);
      e.req  = w;
      e.wr   = 1'b0;
      e.to   = 1'b0;
      e.addr = ADDR_W'(12'h010 + w);
      e.data = m_mem[e.addr];
      lat_q.push_back(int'($urandom_range(0, 3)));
      exp_q.push_back(e);
      m_last = w;
    end
    req_idx = {12'h012, 12'h011, 12'h010};
    req_rd  = 3'b111;
    run(first);
    hold = 1'b0;

    // Random batches
    for (int b = 0; b < 30; b++) begin
      rr = NREQ'($urandom);
      ww = NREQ'($urandom);
      if ((rr | ww) == 0) rr = 3'b001;
      launch(rr, ww,
             {ADDR_W'(12'h300 + $urandom_range(0, 7)), ADDR_W'(12'h300 + $urandom_range(0, 7)),
              ADDR_W'(12'h300 + $urandom_range(0, 7))},
             NREQ*DATA_W'($urandom), -1);
      run(first);
    end

    // Reset in the middle of a read, then a late ack from memory
    launch(3'b001, 3'b000, {12'h0, 12'h0, 12'h055}, '0, 99);
    cyc();
    cyc();
    cyc();
    chk("midread_busy", 32'(mem_read), 32'd1);
    reset = 1'b1;
    req_rd = '0;
    req_wr = '0;
    exp_q.delete();
    lat_q.delete();
    m_terr = 1'b0;
    m_last = NREQ - 1;
    cyc();
    reset = 1'b0;
    force_stray = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("post_rst_mem_read", 32'(mem_read), 32'd0);
      chk("post_rst_rd_ack", 32'(rd_ack), 32'd0);
    end
    force_stray = 1'b0;
    launch(3'b110, 3'b010, {12'h0A0, 12'h0A1, 12'h0}, {8'h11, 8'h22, 8'h0}, -1);
    run(first);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
